// File: rtl/run_sequencer.sv
// run_sequencer
//   Launches NPROG programs on a processor core back-to-back. For each
//   program the core is held in reset for RST_CYC cycles, then gets a single
//   core_req pulse. The block counts RUN cycles until core_done. If core_done
//   does not arrive within TIMEOUT RUN cycles, the sequence aborts into TMO.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   start        begin a sequence (honoured in IDLE, DONE and TMO only)
//   core_done    completion flag from the core (honoured in RUN only)
//   core_reset   reset to the core (high whenever no program is running)
//   core_req     one-cycle launch request to the core
//   prog_sel     index of the program currently or last run
//   busy         high in RST, REQ and RUN
//   finished     all NPROG programs completed
//   timeout      a program exceeded TIMEOUT RUN cycles
//   last_cycles  RUN-cycle count of the most recently completed program
//   total_cycles sum of last_cycles over the current sequence

module run_sequencer #(
  parameter int unsigned RST_CYC = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000,
  parameter int unsigned NPROG   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        core_done,
  output logic        core_reset,
  output logic        core_req,
  output logic [1:0]  prog_sel,
  output logic        busy,
  output logic        finished,
  output logic        timeout,
  output logic [15:0] last_cycles,
  output logic [19:0] total_cycles
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    REQ  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4,
    TMO  = 3'd5
  } state_t;

  localparam logic [7:0]  RST_LAST  = 8'(RST_CYC - 1);
  localparam logic [1:0]  PROG_LAST = 2'(NPROG - 1);
  localparam logic [15:0] RUN_LAST  = TIMEOUT - 16'd1;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  rst_cnt;
  logic [15:0] run_cnt;
  logic [15:0] run_inc;
  logic        idle_like;

  // run_cnt counts RUN cycles already completed, so the current RUN cycle
  // number is run_cnt + 1.
  assign run_inc   = run_cnt + 16'd1;
  assign idle_like = (state == IDLE) || (state == DONE) || (state == TMO);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. core_done wins over the timeout limit when both land
  // on the same RUN cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, TMO: begin
        if (start) begin
          state_nxt = RST;
        end
      end
      RST: begin
        if (rst_cnt == RST_LAST) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (core_done) begin
          state_nxt = (prog_sel == PROG_LAST) ? DONE : RST;
        end else if (run_cnt == RUN_LAST) begin
          state_nxt = TMO;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counters and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt      <= 8'd0;
      run_cnt      <= 16'd0;
      prog_sel     <= 2'd0;
      last_cycles  <= 16'd0;
      total_cycles <= 20'd0;
    end else begin
      if (idle_like) begin
        if (start) begin
          rst_cnt      <= 8'd0;
          run_cnt      <= 16'd0;
          prog_sel     <= 2'd0;
          last_cycles  <= 16'd0;
          total_cycles <= 20'd0;
        end
      end else if (state == RST) begin
        // Leave both counters cleared so REQ starts with run_cnt == 0 and
        // the next RST period starts from zero.
        if (rst_cnt == RST_LAST) begin
          rst_cnt <= 8'd0;
          run_cnt <= 16'd0;
        end else begin
          rst_cnt <= rst_cnt + 8'd1;
        end
      end else if (state == REQ) begin
        run_cnt <= 16'd0;
      end else if (state == RUN) begin
        run_cnt <= run_inc;
        if (core_done) begin
          last_cycles  <= run_inc;
          total_cycles <= total_cycles + {4'd0, run_inc};
          if (prog_sel != PROG_LAST) begin
            prog_sel <= prog_sel + 2'd1;
          end
        end
      end
    end
  end

  // Moore output decode from the state register.
  always_comb begin
    core_reset = 1'b1;
    core_req   = 1'b0;
    busy       = 1'b0;
    finished   = 1'b0;
    timeout    = 1'b0;
    case (state)
      RST: begin
        busy = 1'b1;
      end
      REQ: begin
        core_reset = 1'b0;
        core_req   = 1'b1;
        busy       = 1'b1;
      end
      RUN: begin
        core_reset = 1'b0;
        busy       = 1'b1;
      end
      DONE: begin
        finished = 1'b1;
      end
      TMO: begin
        timeout = 1'b1;
      end
      default: begin
        core_reset = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer
//   Scoreboarded bench for run_sequencer with RST_CYC=4, TIMEOUT=100,
//   NPROG=3. A behavioural core answers each core_req with core_done on a
//   chosen RUN cycle. The stimulus process queues expected launch and
//   end-of-sequence events; the monitor pops and compares them as the DUT
//   presents core_req pulses and finished/timeout edges.

module tb_run_sequencer;

  localparam int RST_CYC = 4;
  localparam int NPROG   = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        core_done;
  logic        core_reset;
  logic        core_req;
  logic [1:0]  prog_sel;
  logic        busy;
  logic        finished;
  logic        timeout;
  logic [15:0] last_cycles;
  logic [19:0] total_cycles;

  typedef struct {
    bit is_end;
    int prog;
    int last;
    int total;
    int run_len;
    bit fin;
    bit tmo;
  } exp_t;

  exp_t exp_q[$];
  int   tgt_q[$];
  int   n_compared;
  int   n_mismatched;
  bit   glitch_rst;
  bit   glitch_req;

  run_sequencer #(
    .RST_CYC(RST_CYC),
    .TIMEOUT(16'd100),
    .NPROG(NPROG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .core_done(core_done),
    .core_reset(core_reset),
    .core_req(core_req),
    .prog_sel(prog_sel),
    .busy(busy),
    .finished(finished),
    .timeout(timeout),
    .last_cycles(last_cycles),
    .total_cycles(total_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and keep the tallies.
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive start/reset just after a falling edge and hold for ncyc cycles.
  task automatic applyStimulus(input logic s, input logic r, input int ncyc);
    start = s;
    reset = r;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic pushReq(input int prog, input int last, input int total);
    exp_t e;
    e = '{is_end: 1'b0, prog: prog, last: last, total: total, run_len: 0, fin: 1'b0, tmo: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic pushEnd(input int prog, input int last, input int total,
                         input int run_len, input bit fin, input bit tmo);
    exp_t e;
    e = '{is_end: 1'b1, prog: prog, last: last, total: total, run_len: run_len, fin: fin, tmo: tmo};
    exp_q.push_back(e);
  endtask

  task automatic waitEnd(input string name, input int budget);
    int n;
    n = 0;
    while (!(finished || timeout) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(finished || timeout)) begin
      checkOutput({name, "_end_reached"}, 0, 1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, "_core_reset"}, int'(core_reset), 1);
    checkOutput({name, "_core_req"}, int'(core_req), 0);
    checkOutput({name, "_busy"}, int'(busy), 0);
    checkOutput({name, "_prog_sel"}, int'(prog_sel), 0);
    checkOutput({name, "_finished"}, int'(finished), 0);
    checkOutput({name, "_timeout"}, int'(timeout), 0);
    checkOutput({name, "_last"}, int'(last_cycles), 0);
    checkOutput({name, "_total"}, int'(total_cycles), 0);
  endtask

  // Behavioural core: raises core_done on the target RUN cycle (0 = never).
  // Optional glitches raise core_done throughout RST and during REQ.
  initial begin
    int cnt;
    int target;
    bit active;
    core_done = 1'b0;
    active    = 1'b0;
    cnt       = 0;
    target    = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active    = 1'b0;
        core_done = 1'b0;
      end else if (core_req) begin
        target    = (tgt_q.size() > 0) ? tgt_q.pop_front() : 0;
        cnt       = 0;
        active    = 1'b1;
        core_done = glitch_req;
      end else if (active) begin
        cnt++;
        core_done = (target != 0) && (cnt == target);
        if (core_done) begin
          active = 1'b0;
        end
      end else begin
        core_done = glitch_rst && busy && core_reset;
      end
    end
  end

  // Monitor: measures RST and RUN lengths and checks each event against
  // the head of the expectation queue.
  initial begin
    int   rst_len;
    int   run_len;
    bit   prev_end;
    bit   end_now;
    exp_t e;
    rst_len  = 0;
    run_len  = 0;
    prev_end = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rst_len  = 0;
        run_len  = 0;
        prev_end = 1'b0;
      end else begin
        if (core_req) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_core_req", int'(prog_sel), -1);
          end else begin
            e = exp_q.pop_front();
            checkOutput("req_is_launch", int'(e.is_end), 0);
            checkOutput("req_prog_sel", int'(prog_sel), e.prog);
            checkOutput("req_rst_len", rst_len, RST_CYC);
            checkOutput("req_last", int'(last_cycles), e.last);
            checkOutput("req_total", int'(total_cycles), e.total);
          end
          rst_len = 0;
          run_len = 0;
        end else if (busy && core_reset) begin
          rst_len++;
        end else if (busy) begin
          run_len++;
        end
        end_now = finished || timeout;
        if (end_now && !prev_end) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_end", int'(prog_sel), -1);
          end else begin
            e = exp_q.pop_front();
            checkOutput("end_is_end", int'(e.is_end), 1);
            checkOutput("end_prog_sel", int'(prog_sel), e.prog);
            checkOutput("end_last", int'(last_cycles), e.last);
            checkOutput("end_total", int'(total_cycles), e.total);
            checkOutput("end_run_len", run_len, e.run_len);
            checkOutput("end_finished", int'(finished), int'(e.fin));
            checkOutput("end_timeout", int'(timeout), int'(e.tmo));
            checkOutput("end_core_reset", int'(core_reset), 1);
            checkOutput("end_busy", int'(busy), 0);
          end
        end
        prev_end = end_now;
      end
    end
  end

  // Stimulus.
  initial begin
    int n;
    n_compared   = 0;
    n_mismatched = 0;
    glitch_rst   = 1'b0;
    glitch_req   = 1'b0;
    reset        = 1'b1;
    start        = 1'b0;
    @(negedge clk);

    // Reset held, then released with start low: stays idle.
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 12);
    checkIdle("idle_after_reset");

    // Three programs of 10 RUN cycles each, with stray start pulses in RST
    // and RUN and stray core_done during RST and REQ.
    pushReq(0, 0, 0);
    pushReq(1, 10, 10);
    pushReq(2, 10, 20);
    pushEnd(2, 10, 30, 10, 1'b1, 1'b0);
    tgt_q = '{10, 10, 10};
    glitch_rst = 1'b1;
    glitch_req = 1'b1;
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1);
    waitEnd("three_programs", 500);
    glitch_rst = 1'b0;
    glitch_req = 1'b0;

    // Restart from DONE: program 0 takes 7 cycles, program 1 never finishes.
    pushReq(0, 0, 0);
    pushReq(1, 7, 7);
    pushEnd(1, 7, 7, 100, 1'b0, 1'b1);
    tgt_q = '{7, 0};
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1);
    waitEnd("timeout_run", 600);

    // Restart from TMO: done exactly on RUN cycle 100 counts as completion.
    pushReq(0, 0, 0);
    pushReq(1, 100, 100);
    pushReq(2, 5, 105);
    pushEnd(2, 3, 108, 3, 1'b1, 1'b0);
    tgt_q = '{100, 5, 3};
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1);
    waitEnd("done_at_limit", 800);

    // Reset on RUN cycle 5 of program 1.
    pushReq(0, 0, 0);
    pushReq(1, 10, 10);
    tgt_q = '{10, 0};
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1);
    n = 0;
    while (!(core_req && prog_sel == 2'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(core_req && prog_sel == 2'd1)) begin
      checkOutput("mid_run_reach_prog1", 0, 1);
    end
    repeat (5) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1);
    checkIdle("reset_mid_run");
    applyStimulus(1'b0, 1'b0, 8);
    checkOutput("idle_hold_busy", int'(busy), 0);
    checkOutput("idle_hold_core_reset", int'(core_reset), 1);

    checkOutput("leftover_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
